instr_fetch_unit: RTL and testbench

//  Fetch stage upstream of Control_Unit_Top: owns the PC, issues in-order word reads to instruction memory,

---
 rtl/instr_fetch_unit_pkg.sv | 14 +
 rtl/instr_fetch_unit_fifo.sv | 88 ++++++++
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - RISC-V opcode constants, NOP encoding and default reset PC for the fetch unit
package instr_fetch_unit_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// rtl/instr_fetch_unit_fifo.sv - ifu_fifo: sync FIFO with flush and a registered head that holds its last value when empty
module ifu_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int              WIDTH      = 64,
  parameter int              DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_HEAD = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  input  logic                         i_touch,
  output logic [WIDTH-1:0]             o_head,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] L_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] L_ONE  = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_pop;
  logic [AW-1:0]    w_rd_next;
  logic [CW-1:0]    w_count_next;
  logic [WIDTH-1:0] w_head_next;

  assign w_pop        = i_pop && (r_count != '0);
  assign w_rd_next    = r_rd_ptr + AW'(1);
  assign w_count_next = r_count + CW'(i_push) - CW'(w_pop);

  // Head register looks one entry ahead so the output is always a flop, never a RAM read path
  always_comb begin
    w_head_next = r_head;
    if (w_pop && (r_count > L_ONE)) begin
      w_head_next = r_mem[w_rd_next];
    end else if (w_pop || (r_count == '0)) begin
      if (i_push || i_touch) begin
        w_head_next = i_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush && !rst) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= RESET_HEAD;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      r_count <= w_count_next;
      r_head  <= w_head_next;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_flush && !w_pop && (r_count == L_FULL)));

  assign o_head  = r_head;
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, in-order imem reads, instruction buffer, redirect flush; IFU_BYPASS_EN adds a 0-latency empty-buffer bypass
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [6:0]      if_op,
  output logic [2:0]      if_funct3,
  output logic [6:0]      if_funct7
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int UW = CW + 1;
  localparam int DW = CW + 3;
  localparam logic [UW-1:0]   L_DEPTH = UW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] L_WORD  = XLEN'(4);
  localparam logic [XLEN-1:0] L_ALIGN = ~XLEN'(3);

  logic [XLEN-1:0]   r_fetch_pc;
  logic [XLEN-1:0]   r_rsp_pc;
  logic [CW-1:0]     r_outstanding;
  logic [DW-1:0]     r_discard;

  logic [CW-1:0]     w_fifo_count;
  logic              w_fifo_valid;
  logic [2*XLEN-1:0] w_fifo_head;
  logic [UW-1:0]     w_used;
  logic              w_req_valid;
  logic              w_accept;
  logic              w_rsp_keep;
  logic              w_rsp_drop;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic [XLEN-1:0]   w_if_instr;
  logic [XLEN-1:0]   w_if_pc;

  // Buffered plus in-flight never exceeds the buffer, so every kept response has a slot
  assign w_used      = UW'(w_fifo_count) + UW'(r_outstanding);
  assign w_req_valid = !rst && !redirect_valid && (w_used < L_DEPTH);
  assign w_accept    = w_req_valid && imem_req_ready;
  assign w_rsp_drop  = imem_rsp_valid && (r_discard != '0);
  assign w_rsp_keep  = imem_rsp_valid && (r_discard == '0) && !redirect_valid && !rst;

`ifdef IFU_BYPASS_EN
  assign w_bypass = w_rsp_keep && !w_fifo_valid && id_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_rsp_keep && !w_bypass;
  assign w_pop  = w_fifo_valid && id_ready;

  // r_rsp_pc tags the next kept response; requests leave in order from a linear PC stream
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= redirect_pc & L_ALIGN;
      r_rsp_pc      <= redirect_pc & L_ALIGN;
      r_outstanding <= '0;
      r_discard     <= r_discard + DW'(r_outstanding) - DW'(imem_rsp_valid);
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + L_WORD;
      end
      if (w_rsp_keep) begin
        r_rsp_pc <= r_rsp_pc + L_WORD;
      end
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp_keep);
      r_discard     <= r_discard - DW'(w_rsp_drop);
    end
  end

  ifu_fifo #(
    .WIDTH      (2 * XLEN),
    .DEPTH      (FIFO_DEPTH),
    .RESET_HEAD ({XLEN'(NOP_INSTR), RESET_PC})
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_wdata ({imem_rsp_data, r_rsp_pc}),
    .i_pop   (w_pop),
    .i_touch (w_bypass),
    .o_head  (w_fifo_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign w_if_instr = w_bypass ? imem_rsp_data : w_fifo_head[2*XLEN-1:XLEN];
  assign w_if_pc    = w_bypass ? r_rsp_pc      : w_fifo_head[XLEN-1:0];

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign if_valid       = w_fifo_valid || w_bypass;
  assign if_instr       = w_if_instr;
  assign if_pc          = w_if_pc;
  assign if_pc_plus4    = w_if_pc + L_WORD;
  assign if_op          = w_if_instr[6:0];
  assign if_funct3      = w_if_instr[14:12];
  assign if_funct7      = w_if_instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit with queue-based reference model
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef IFU_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
  logic [6:0]  if_op, if_funct7;
  logic [2:0]  if_funct3;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .if_op(if_op), .if_funct3(if_funct3), .if_funct7(if_funct7)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_2083;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  // Stimulus knobs, applied at each falling edge
  logic        k_rst, k_ready, k_rsp_en, k_redir, k_id_ready;
  logic [31:0] k_redir_pc;

  typedef struct { logic [31:0] addr; int acc; } mreq_t;
  typedef struct { logic [31:0] pc; bit stale; } inf_t;
  mreq_t       mem_q[$];
  inf_t        m_inf[$];
  logic [31:0] m_fifo_pc[$];
  logic [31:0] m_fetch, m_last_instr, m_last_pc;
  bit          m_known = 0;
  int          cyc = 0;

  logic        s_req_valid, s_if_valid;
  logic [31:0] s_req_addr, s_if_instr, s_if_pc, s_if_pc4;

  task automatic cycle();
    bit          rsp_v, e_req, e_byp, e_ifv;
    int          live;
    logic [31:0] e_pc, e_instr;
    @(negedge clk);
    rst            = k_rst;
    imem_req_ready = k_ready;
    redirect_valid = k_redir;
    redirect_pc    = k_redir_pc;
    id_ready       = k_id_ready;
    rsp_v = !k_rst && k_rsp_en && (mem_q.size() > 0) && (mem_q[0].acc < cyc);
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_v ? memfn(mem_q[0].addr) : 32'hDEAD_BEEF;
    #1;
    s_req_valid = imem_req_valid;  s_req_addr = imem_req_addr;
    s_if_valid  = if_valid;        s_if_instr = if_instr;
    s_if_pc     = if_pc;           s_if_pc4   = if_pc_plus4;

    live = 0;
    foreach (m_inf[i]) if (!m_inf[i].stale) live++;
    e_req = !k_rst && !k_redir && ((m_fifo_pc.size() + live) < DEPTH);
    e_byp = (BYP != 0) && !k_rst && !k_redir && rsp_v && k_id_ready &&
            (m_fifo_pc.size() == 0) && (m_inf.size() > 0) && !m_inf[0].stale;
    e_ifv = (m_fifo_pc.size() > 0) || e_byp;
    if (e_byp)                    e_pc = m_inf[0].pc;
    else if (m_fifo_pc.size() > 0) e_pc = m_fifo_pc[0];
    else                           e_pc = m_last_pc;
    e_instr = e_ifv ? memfn(e_pc) : m_last_instr;

    if (m_known) begin
      chk("req_valid", s_req_valid, e_req);
      if (e_req) chk("req_addr", s_req_addr, m_fetch);
      chk("if_valid", s_if_valid, e_ifv);
      chk("if_instr", s_if_instr, e_instr);
      chk("if_pc", s_if_pc, e_pc);
      chk("if_pc_plus4", s_if_pc4, e_pc + 32'd4);
      chk("if_op", if_op, e_instr[6:0]);
      chk("if_funct3", if_funct3, e_instr[14:12]);
      chk("if_funct7", if_funct7, e_instr[31:25]);
    end

    @(posedge clk);
    if (k_rst) mem_q.delete();
    else begin
      if (rsp_v) void'(mem_q.pop_front());
      if (s_req_valid && k_ready) mem_q.push_back('{s_req_addr, cyc});
    end
    cyc++;

    if (k_rst) begin
      m_inf.delete(); m_fifo_pc.delete();
      m_fetch = RPC; m_last_instr = NOP_INSTR; m_last_pc = RPC; m_known = 1;
    end else begin
      if (e_ifv) begin m_last_pc = e_pc; m_last_instr = e_instr; end
      if (k_redir) begin
        if (rsp_v && m_inf.size() > 0) void'(m_inf.pop_front());
        foreach (m_inf[i]) m_inf[i].stale = 1;
        m_fifo_pc.delete();
        m_fetch = k_redir_pc & ~32'h3;
      end else begin
        if (m_fifo_pc.size() > 0 && k_id_ready) void'(m_fifo_pc.pop_front());
        if (rsp_v && m_inf.size() > 0) begin
          inf_t f;
          f = m_inf.pop_front();
          if (!f.stale && !e_byp) m_fifo_pc.push_back(f.pc);
        end
        if (e_req && k_ready) begin
          m_inf.push_back('{m_fetch, 1'b0});
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_valid(input int max, output int idx);
    idx = -1;
    for (int i = 0; i < max; i++) begin
      cycle();
      if (s_if_valid) begin idx = i; break; end
    end
  endtask

  initial begin
    int first, nvalid, nacc, idx;
    bit seen_wrap, seen_pc4;
    logic [31:0] prev_acc;
    k_rst = 1; k_ready = 1; k_rsp_en = 1; k_redir = 0; k_redir_pc = 0; k_id_ready = 1;
    rst = 1; imem_req_ready = 1; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; id_ready = 1;

    // 1: reset values, first instruction, latency, throughput
    run(2); k_rst = 0;
    cycle();
    chk("t1_req_valid", s_req_valid, 1);
    chk("t1_req_addr", s_req_addr, 32'h0);
    chk("t1_if_valid", s_if_valid, 0);
    chk("t1_nop", s_if_instr, 32'h0000_0013);
    chk("t1_pc4", s_if_pc4, 32'h4);
    first = -1; nvalid = 0;
    for (int i = 1; i < 12; i++) begin
      cycle();
      if (s_if_valid && first < 0) begin
        first = i;
        chk("t1_op", if_op, OP_LOAD);
        chk("t1_pc", s_if_pc, 32'h0);
        chk("t1_first_pc4", s_if_pc4, 32'h4);
      end
      if (i >= 3 && s_if_valid) nvalid++;
    end
    chk("t1_latency", first, 2 - BYP);
    chk("t1_throughput", nvalid, 9);

    // 2: stalled decode fills exactly DEPTH credits, then drains in order
    k_rst = 1; cycle(); k_rst = 0; k_id_ready = 0; nacc = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_req_valid && k_ready) nacc++;
    end
    chk("t2_requests", nacc, 4);
    chk("t2_req_stop", s_req_valid, 0);
    chk("t2_hold_pc", s_if_pc, 32'h0);
    k_id_ready = 1;
    for (int j = 0; j < 4; j++) begin
      cycle();
      chk("t2_drain_pc", s_if_pc, 32'(4 * j));
    end

    // 3: redirect to 0x103 with two reads outstanding
    k_rst = 1; cycle(); k_rst = 0; k_rsp_en = 0;
    run(2);
    k_redir = 1; k_redir_pc = 32'h103; cycle();
    chk("t3_no_req", s_req_valid, 0);
    k_redir = 0; k_rsp_en = 1; cycle();
    chk("t3_addr", s_req_addr, 32'h100);
    chk("t3_if_valid", s_if_valid, 0);
    wait_valid(8, idx);
    chk("t3_wait", idx + 1, 3 - BYP);
    chk("t3_first_pc", s_if_pc, 32'h100);

    // 4: redirect coinciding with response and pop
    run(4);
    k_redir = 1; k_redir_pc = 32'h200; cycle();
    chk("t4_pre_valid", s_if_valid, 1);
    k_redir = 0; cycle();
    chk("t4_flushed", s_if_valid, 0);
    chk("t4_addr", s_req_addr, 32'h200);
    wait_valid(8, idx);
    chk("t4_first_pc", s_if_pc, 32'h200);

    // 5: PC wraps past 0xFFFF_FFFC
    k_redir = 1; k_redir_pc = 32'hFFFF_FFF8; cycle(); k_redir = 0;
    seen_wrap = 0; seen_pc4 = 0; prev_acc = 32'h1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (prev_acc == 32'hFFFF_FFFC && s_req_valid && !seen_wrap) begin
        chk("t5_wrap_addr", s_req_addr, 32'h0);
        seen_wrap = 1;
      end
      if (s_if_valid && s_if_pc == 32'hFFFF_FFFC) begin
        chk("t5_pc4", s_if_pc4, 32'h0);
        seen_pc4 = 1;
      end
      if (s_req_valid && k_ready) prev_acc = s_req_addr;
    end
    chk("t5_seen_wrap", seen_wrap, 1);
    chk("t5_seen_pc4", seen_pc4, 1);

    // 7: back-to-back redirects with reads in flight; last one wins
    k_rsp_en = 0; run(2);
    k_redir = 1; k_redir_pc = 32'h300; cycle();
    k_rsp_en = 1; k_redir_pc = 32'h400; cycle();
    k_redir = 0;
    wait_valid(10, idx);
    chk("t7_found", (idx >= 0), 1);
    chk("t7_first_pc", s_if_pc, 32'h400);

    // 6: reset mid-stream with a full buffer
    k_id_ready = 0; run(8);
    chk("t6_full_stop", s_req_valid, 0);
    chk("t6_full_valid", s_if_valid, 1);
    k_rst = 1; cycle(); k_rst = 0; k_id_ready = 1;
    cycle();
    chk("t6_if_valid", s_if_valid, 0);
    chk("t6_req_valid", s_req_valid, 1);
    chk("t6_req_addr", s_req_addr, RPC);
    first = -1;
    for (int i = 1; i < 5; i++) begin
      cycle();
      if (s_if_valid && first < 0) first = i;
    end
    chk("t6_latency", first, 2 - BYP);
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
